// File: rtl/global_pool_if.sv
// Stream bundle for global_pool: sample input stream and per-channel result stream.
interface global_pool_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CHANNELS   = 16
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic                  ready_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic [CH_W-1:0]       out_ch;
   logic                  last_out;
   logic                  valid_out;
   logic                  ready_out;

   modport master (
      output data_in, valid_in, ready_out,
      input  ready_in, data_out, out_ch, last_out, valid_out
   );

   modport slave (
      input  data_in, valid_in, ready_out,
      output ready_in, data_out, out_ch, last_out, valid_out
   );
endinterface

// File: rtl/global_pool.sv
// Global pooling stage: per-channel sum / rounded average / max over a channel-major frame.
// Define GLOBAL_POOL_MAX_EN to compile in max pooling (mode 2); otherwise mode 2 behaves as sum.
module global_pool #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int CHANNELS   = 16,
   parameter int FRAME_LEN  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        mode,
   global_pool_if.slave      pool_if,
   output logic              sat_flag,
   output logic              busy,
   output logic              done
);
   localparam int SHIFT = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 0;
   localparam int POS_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [POS_W-1:0] POS_LAST = POS_W'(FRAME_LEN - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

   // Rounding constant 2^(SHIFT-1); evaluates to 0 when SHIFT is 0.
   localparam logic signed [ACC_WIDTH:0] RND    = (ACC_WIDTH+1)'((2**SHIFT) / 2);
   localparam logic signed [ACC_WIDTH:0] SAT_HI = {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] SAT_LO = {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`ifdef GLOBAL_POOL_MAX_EN
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUTPUT, S_DONE} state_t;

   state_t                       state_q, state_d;
   logic [1:0]                   mode_q, mode_d;
   logic [POS_W-1:0]             pos_q, pos_d;
   logic [CH_W-1:0]              ch_q, ch_d;
   logic [CH_W-1:0]              out_q, out_d;
   logic                         sat_q, sat_d;
   logic signed [ACC_WIDTH-1:0]  acc_q [CHANNELS];
   logic signed [ACC_WIDTH-1:0]  acc_d [CHANNELS];

   logic signed [DATA_WIDTH-1:0] din_s;
   logic signed [ACC_WIDTH-1:0]  din_ext;
   logic signed [ACC_WIDTH:0]    res;
   logic                         is_avg;
`ifdef GLOBAL_POOL_MAX_EN
   logic                         is_max;
`endif

   function automatic logic signed [ACC_WIDTH:0] pool_result(
      input logic signed [ACC_WIDTH-1:0] a,
      input logic                        avg
   );
      logic signed [ACC_WIDTH:0] ext;
      ext = (ACC_WIDTH+1)'(a);
      // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
      if (avg) return (ext + RND) >>> SHIFT;
      return ext;
   endfunction

   function automatic logic sat_hit(input logic signed [ACC_WIDTH:0] v);
      return (v > SAT_HI) || (v < SAT_LO);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sat_value(input logic signed [ACC_WIDTH:0] v);
      if (v > SAT_HI) return SAT_HI[DATA_WIDTH-1:0];
      if (v < SAT_LO) return SAT_LO[DATA_WIDTH-1:0];
      return v[DATA_WIDTH-1:0];
   endfunction

   assign din_s   = pool_if.data_in;
   assign din_ext = ACC_WIDTH'(din_s);
   assign is_avg  = (mode_q == 2'd1);
`ifdef GLOBAL_POOL_MAX_EN
   assign is_max  = (mode_q == 2'd2);
`endif

   // Result path reads only registers, so output-side backpressure cannot disturb it.
   assign res                = pool_result(acc_q[out_q], is_avg);
   assign pool_if.data_out   = sat_value(res);
   assign pool_if.out_ch     = out_q;
   assign pool_if.valid_out  = (state_q == S_OUTPUT);
   assign pool_if.last_out   = (state_q == S_OUTPUT) && (out_q == CH_LAST);
   assign pool_if.ready_in   = (state_q == S_ACC);
   assign busy               = (state_q == S_ACC) || (state_q == S_OUTPUT);
   assign done               = (state_q == S_DONE);
   assign sat_flag           = sat_q;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      pos_d   = pos_q;
      ch_d    = ch_q;
      out_d   = out_q;
      sat_d   = sat_q;
      acc_d   = acc_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACC;
               mode_d  = mode;
               pos_d   = '0;
               ch_d    = '0;
               out_d   = '0;
               sat_d   = 1'b0;
               for (int c = 0; c < CHANNELS; c++) begin
`ifdef GLOBAL_POOL_MAX_EN
                  acc_d[c] = (mode == 2'd2) ? ACC_MIN : '0;
`else
                  acc_d[c] = '0;
`endif
               end
            end
         end
         S_ACC: begin
            if (pool_if.valid_in) begin
`ifdef GLOBAL_POOL_MAX_EN
               if (is_max) begin
                  if (din_ext > acc_q[ch_q]) acc_d[ch_q] = din_ext;
               end else begin
                  acc_d[ch_q] = acc_q[ch_q] + din_ext;
               end
`else
               acc_d[ch_q] = acc_q[ch_q] + din_ext;
`endif
               if (pos_q == POS_LAST) begin
                  pos_d = '0;
                  if (ch_q == CH_LAST) state_d = S_OUTPUT;
                  else                 ch_d    = ch_q + 1'b1;
               end else begin
                  pos_d = pos_q + 1'b1;
               end
            end
         end
         S_OUTPUT: begin
            if (pool_if.ready_out) begin
               if (sat_hit(res)) sat_d = 1'b1;
               if (out_q == CH_LAST) begin
                  out_d   = '0;
                  state_d = S_DONE;
               end else begin
                  out_d = out_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= 2'd0;
         pos_q   <= '0;
         ch_q    <= '0;
         out_q   <= '0;
         sat_q   <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pos_q   <= pos_d;
         ch_q    <= ch_d;
         out_q   <= out_d;
         sat_q   <= sat_d;
         acc_q   <= acc_d;
      end
   end
endmodule

// File: doc/global_pool.md
# global_pool

Parametrised global pooling stage for the discriminator tail. It reduces each channel of a channel-major feature stream (ch0[0..N-1], ch1[0..N-1], …) to one value per channel. The reduction mode is selectable per frame: sum, rounded average or maximum. The block has full ready/valid flow control on both sides and saturating Q-format output. It feeds the final dense layer.

## Interface
- `DATA_WIDTH`, 16 — signed input/output sample width (Q8.8 at default).
- `ACC_WIDTH`, 32 — accumulator width; must be ≥ DATA_WIDTH + $clog2(FRAME_LEN).
- `CHANNELS`, 16 — channels per frame, ≥1.
- `FRAME_LEN`, 4 — spatial samples per channel, power of 2, ≥1.

Ports:
- `clk` in 1 — the block's only clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `start` in 1 — begin a frame; honoured only in IDLE.
- `mode` in 2 — 0 sum, 1 average, 2 max (macro-dependent), 3 reserved; latched on accepted `start`.
- `data_in` in DATA_WIDTH — signed input sample.
- `valid_in` in 1 / `ready_in` out 1 — input handshake.
- `data_out` out DATA_WIDTH — saturated per-channel result.
- `out_ch` out $clog2(CHANNELS) (min 1) — channel index of `data_out`.
- `last_out` out 1 — high with the final channel's beat.
- `valid_out` out 1 / `ready_out` in 1 — output handshake.
- `sat_flag` out 1 — sticky; set if any output of the current frame clamped.
- `busy` out 1 — high in ACC and OUTPUT.
- `done` out 1 — one-cycle pulse in DONE.

## Operation
- FSM has four states: IDLE → ACC on `start`. ACC → OUTPUT on acceptance of beat (CHANNELS-1, FRAME_LEN-1). OUTPUT → DONE on handshake of channel CHANNELS-1. DONE → IDLE unconditionally.
- On accepted `start`:
  - `mode` is latched.
  - Counters are cleared.
  - `sat_flag` is cleared.
  - Accumulators are set to 0 for sum/average, or to the most negative ACC_WIDTH value for max.
- ACC: a beat is accepted when `valid_in && ready_in`.
  - Sum/average: `acc[ch] += sign-extend(data_in)`.
  - Max: `acc[ch] = max(acc[ch], data_in)`.
  - `pos_cnt` counts 0..FRAME_LEN-1. On wrap, `ch_cnt` increments.
- Result per channel:
  - Sum: `acc`.
  - Average with SHIFT = $clog2(FRAME_LEN) > 0: `(acc + 2^(SHIFT-1)) >>> SHIFT`, i.e. round half toward +∞. With SHIFT = 0: `acc`.
  - Max: `acc`.
  - The result is then clamped to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1]. A clamp on a handshaken beat sets `sat_flag`.
- OUTPUT: channel `out_cnt` is presented. `out_cnt` increments only on `valid_out && ready_out`.
- Mode 3, or mode 2 when the macro is absent, behaves exactly as sum.
- `start` outside IDLE is ignored. `valid_in` outside ACC is ignored, since `ready_in` is low.

## Timing
- Reset values:
  - state IDLE.
  - `ready_in`, `valid_out`, `last_out`, `busy`, `done`, `sat_flag` = 0.
  - `data_out` = 0, `out_ch` = 0.
  - All accumulators and counters = 0.
- `ready_in` is a function of registered state only. `valid_out`, `data_out`, `out_ch`, `last_out` depend only on registers. There is no combinational `ready_out`→output or `data_in`→output path.
- `start` sampled at edge t: `ready_in` and `busy` are high from t+1.
- Last input accepted at edge e: `valid_out` is high from e+1, showing channel 0. The final channel's accumulator is already valid at e+1, including when CHANNELS = 1.
- With `ready_out` held high, one channel is emitted per cycle. `done` pulses the cycle after the last output handshake; `busy` is low in that same cycle.
- Minimum frame time with no stalls: 1 + CHANNELS·FRAME_LEN + CHANNELS + 1 cycles.
- Backpressure: while `valid_out && !ready_out`, `data_out`, `out_ch` and `last_out` hold stable. `valid_out` never drops before its handshake.
- Input gaps (`valid_in` low) stall counters without side effects.
- `rst_n` asserted mid-frame: immediate return to reset values. Partial results are discarded and no `done` is issued.

## Configuration
- `GLOBAL_POOL_MAX_EN` defined: mode 2 performs max pooling. The comparator path and the most-negative init are compiled in.
- Undefined: there is no comparator logic, and mode 2 aliases to sum.

## Test plan
- Sum, CHANNELS=4, FRAME_LEN=4: channel k fed four samples of 0x0100·(k+1). Required outputs 0x0400, 0x0800, 0x0C00, 0x1000; `last_out` high on beat 3; `done` one cycle later; `sat_flag`=0.
- Average: ch0 fed 1,2,3,4 → 3. ch1 fed −1,−2,−3,−4 → −2 (0xFFFE). ch2 fed 2,2,2,3 → 2.
- Saturation, sum mode: ch0 fed 0x7000 ×4 → 0x7FFF. ch1 fed 0x8000 ×4 → 0x8000. `sat_flag`=1 after the first output handshake and until the next `start`.
- Max, with macro: ch0 fed −5, 3, 0x7FFF, 0x8000 → 0x7FFF. ch1 fed −9 ×4 → 0xFFF7. Without macro, the same stimulus gives the sum result.
- Flow control: `valid_in` random 50% and `ready_out` toggling every cycle. Results must be identical to the stall-free run, and `data_out` must be stable during every stalled cycle.
- Reset mid-ACC after 6 beats, then a fresh `start` with all-0x0001 input: outputs 0x0004 per channel (sum), with no leftover contribution from the aborted frame.
